// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared frame-capture constants and controller state encoding
package fft_ctrl_pkg;
  localparam int FFT_N = 16;
  localparam int SAMPLE_W = 8;
  typedef enum logic [1:0] {IDLE, FILL, FLUSH, FULL} frame_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones, cleared only by reset
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl: sequences sample shifts into the FFT input register and
// freezes the captured frame until the FFT acknowledges it
module shift_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int W  = SAMPLE_W,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  input  logic          abort,
  input  logic [W-1:0]  sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          sr_en,
  output logic [W-1:0]  sr_data,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [CW-1:0] fill_count,
  output logic [7:0]    drop_count,
  output logic          busy
);
  frame_state_t state, state_nx;
  logic accept, frozen, clear_fill;
  assign sample_ready = state == FILL;
  assign busy         = state != IDLE;
  assign accept       = sample_valid & sample_ready;
  assign frozen       = state == FLUSH || state == FULL;
  assign clear_fill   = abort || (state == IDLE && start) || (state == FULL && frame_ack && continuous);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = start ? FILL : IDLE;
      FILL:  state_nx = (accept && fill_count == CW'(N - 1)) ? FLUSH : FILL;
      FLUSH: state_nx = FULL;
      FULL:  state_nx = frame_ack ? (continuous ? FILL : IDLE) : FULL;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      frame_valid <= 1'b0;
      sr_en       <= 1'b0;
      sr_data     <= '0;
      fill_count  <= '0;
    end else begin
      state       <= state_nx;
      frame_valid <= state_nx == FULL;
      sr_en       <= accept & ~abort;
      if (accept) sr_data <= sample_in;
      if (clear_fill) fill_count <= '0;
      else if (accept) fill_count <= fill_count + 1'b1;
    end
  // samples offered while frozen are lost; the abort edge leaves the count untouched
  sat_counter #(.W(8)) u_drop (
    .clk  (clk),
    .rst  (rst),
    .en   (sample_valid & frozen & ~abort),
    .count(drop_count)
  );
endmodule

// File: tb/tb_shift_frame_ctrl.sv
// tb_shift_frame_ctrl: directed scoreboard bench for the frame capture sequencer
module tb_shift_frame_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 0, continuous = 0, abort = 0, sample_valid = 0, frame_ack = 0;
  logic [7:0] sample_in = 0;
  logic       sample_ready, sr_en, frame_valid, busy;
  logic [7:0] sr_data, drop_count;
  logic [4:0] fill_count;
  int         checks = 0, errors = 0, cyc = 0;
  int         rise [3];
  logic [7:0] q [$];
  logic [7:0] sr_model [16];

  always #5 clk = ~clk;

  shift_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sr_en(sr_en), .sr_data(sr_data), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .fill_count(fill_count), .drop_count(drop_count), .busy(busy)
  );

  `define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

  task automatic tick();
    logic       acc;
    logic [7:0] d, e;
    acc = sample_valid && sample_ready;
    d   = sample_in;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) q.push_back(d);
    if (sr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sr_en_spurious observed=1 expected=0");
      end else begin
        e = q.pop_front();
        `CHK("sr_data", sr_data, e)
        for (int j = 15; j > 0; j--) sr_model[j] = sr_model[j-1];
        sr_model[0] = sr_data;
      end
    end
  endtask

  task automatic start_capture(input logic cont);
    continuous = cont;
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    logic ok;
    #12;
    `CHK("rst_ready", sample_ready, 1'b0)
    `CHK("rst_sr_en", sr_en, 1'b0)
    `CHK("rst_sr_data", sr_data, 8'h00)
    `CHK("rst_frame_valid", frame_valid, 1'b0)
    `CHK("rst_fill", fill_count, 5'd0)
    `CHK("rst_drop", drop_count, 8'd0)
    `CHK("rst_busy", busy, 1'b0)
    rst = 0;
    // single shot, samples 1,8,15,...
    start_capture(1'b0);
    `CHK("ss_ready", sample_ready, 1'b1)
    `CHK("ss_fill0", fill_count, 5'd0)
    sample_valid = 1;
    for (int i = 0; i < 16; i++) begin
      sample_in = 8'(1 + 7 * i);
      tick();
      `CHK("ss_sr_en_pulse", sr_en, 1'b1)
    end
    `CHK("ss_flush_fv", frame_valid, 1'b0)
    `CHK("ss_flush_ready", sample_ready, 1'b0)
    tick();
    `CHK("ss_fv", frame_valid, 1'b1)
    `CHK("ss_fill16", fill_count, 5'd16)
    `CHK("ss_queue_empty", q.size(), 0)
    ok = 1;
    for (int i = 0; i < 16; i++) ok &= sr_model[15-i] == 8'(1 + 7 * i);
    `CHK("ss_frame_order", ok, 1'b1)
    // freeze with drops
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      ok &= !sr_en && frame_valid;
    end
    `CHK("frz_stable", ok, 1'b1)
    `CHK("frz_drop21", drop_count, 8'd21)
    ok = 1;
    for (int i = 0; i < 16; i++) ok &= sr_model[15-i] == 8'(1 + 7 * i);
    `CHK("frz_frame_kept", ok, 1'b1)
    sample_valid = 0;
    frame_ack = 1;
    tick();
    frame_ack = 0;
    `CHK("ss_ack_fv", frame_valid, 1'b0)
    `CHK("ss_ack_busy", busy, 1'b0)
    // continuous: three frames, ack in first FULL cycle
    start_capture(1'b1);
    sample_valid = 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        sample_in = 8'(f * 16 + i + 3);
        tick();
      end
      `CHK("ct_flush_ready", sample_ready, 1'b0)
      tick();
      `CHK("ct_fv", frame_valid, 1'b1)
      `CHK("ct_full_ready", sample_ready, 1'b0)
      rise[f] = cyc;
      continuous = f < 2;
      frame_ack = 1;
      tick();
      frame_ack = 0;
      `CHK("ct_ack_fv", frame_valid, 1'b0)
      `CHK("ct_ack_ready", sample_ready, logic'(f < 2))
    end
    sample_valid = 0;
    `CHK("ct_period01", rise[1] - rise[0], 18)
    `CHK("ct_period12", rise[2] - rise[1], 18)
    `CHK("ct_drop27", drop_count, 8'd27)
    // backpressure, valid every other cycle
    start_capture(1'b0);
    for (int i = 0; i < 32; i++) begin
      sample_valid = (i % 2) == 0;
      sample_in = 8'($urandom);
      tick();
      if (i == 30) `CHK("bp_early_fv", frame_valid, 1'b0)
    end
    sample_valid = 0;
    `CHK("bp_fv", frame_valid, 1'b1)
    `CHK("bp_fill16", fill_count, 5'd16)
    `CHK("bp_drop", drop_count, 8'd27)
    frame_ack = 1;
    tick();
    frame_ack = 0;
    `CHK("bp_idle", busy, 1'b0)
    // abort mid-fill
    start_capture(1'b0);
    sample_valid = 1;
    for (int i = 0; i < 9; i++) begin
      sample_in = 8'(200 + i);
      tick();
    end
    sample_valid = 0;
    `CHK("ab_fill9", fill_count, 5'd9)
    abort = 1;
    tick();
    abort = 0;
    `CHK("ab_busy", busy, 1'b0)
    `CHK("ab_fill0", fill_count, 5'd0)
    `CHK("ab_sr_en", sr_en, 1'b0)
    `CHK("ab_drop_kept", drop_count, 8'd27)
    start_capture(1'b1);
    `CHK("ab_restart_fill", fill_count, 5'd0)
    `CHK("ab_restart_ready", sample_ready, 1'b1)
    sample_valid = 1;
    for (int i = 0; i < 16; i++) begin
      sample_in = 8'(100 + i);
      tick();
    end
    sample_valid = 0;
    tick();
    `CHK("ab_full_fv", frame_valid, 1'b1)
    abort = 1;
    frame_ack = 1;
    tick();
    abort = 0;
    frame_ack = 0;
    `CHK("ab_ack_busy", busy, 1'b0)
    `CHK("ab_ack_fv", frame_valid, 1'b0)
    `CHK("ab_ack_ready", sample_ready, 1'b0)
    // saturation of drop_count
    start_capture(1'b0);
    sample_valid = 1;
    for (int i = 0; i < 16; i++) begin
      sample_in = 8'(50 + i);
      tick();
    end
    for (int i = 0; i < 300; i++) tick();
    `CHK("sat_drop255", drop_count, 8'd255)
    `CHK("sat_fv", frame_valid, 1'b1)
    sample_valid = 0;
    // asynchronous reset between edges
    #2 rst = 1;
    #1;
    `CHK("ar_ready", sample_ready, 1'b0)
    `CHK("ar_sr_en", sr_en, 1'b0)
    `CHK("ar_sr_data", sr_data, 8'h00)
    `CHK("ar_fv", frame_valid, 1'b0)
    `CHK("ar_fill", fill_count, 5'd0)
    `CHK("ar_drop", drop_count, 8'd0)
    `CHK("ar_busy", busy, 1'b0)
    @(negedge clk);
    rst = 0;
    q.delete();
    tick();
    `CHK("ar_after_idle", busy, 1'b0)
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
